// File: rtl/serial_comparator.sv
// serial_comparator: bit-serial, MSB-first unsigned magnitude comparator behind a start/done handshake.
// Optional build macro EARLY_EXIT_EN ends the walk on the first differing bit instead of after every bit.
module serial_comparator #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  a_in_g_b_in,
    output logic                  a_in_e_b_in,
    output logic                  a_in_l_b_in
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ,
        REL_GT,
        REL_LT
    } rel_t;

    state_t                state;
    state_t                next_state;
    rel_t                  rel;
    rel_t                  rel_next;
    logic [DATA_WIDTH-1:0] a_sh;
    logic [DATA_WIDTH-1:0] b_sh;
    logic [CNT_W-1:0]      cnt;
    logic                  a_msb;
    logic                  b_msb;
    logic                  finish;

    assign a_msb    = a_sh[DATA_WIDTH-1];
    assign b_msb    = b_sh[DATA_WIDTH-1];
    assign busy_out = (state == SHIFT);

    // Once a difference has been seen, the relation is frozen for the rest of the walk.
    always_comb begin
        rel_next = rel;
        if ((rel == REL_EQ) && (a_msb != b_msb)) begin
            rel_next = a_msb ? REL_GT : REL_LT;
        end
    end

    always_comb begin
        finish = 1'b0;
        if (state == SHIFT) begin
`ifdef EARLY_EXIT_EN
            finish = (cnt == '0) || (rel_next != REL_EQ);
`else
            finish = (cnt == '0);
`endif
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_in) next_state = SHIFT;
            SHIFT:   if (finish)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start is only honoured in IDLE, so the done edge (still SHIFT) never re-captures operands.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_sh        <= '0;
            b_sh        <= '0;
            cnt         <= '0;
            rel         <= REL_EQ;
            done_out    <= 1'b0;
            a_in_g_b_in <= 1'b0;
            a_in_e_b_in <= 1'b0;
            a_in_l_b_in <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh <= a_in;
                        b_sh <= b_in;
                        cnt  <= CNT_W'(DATA_WIDTH - 1);
                        rel  <= REL_EQ;
                    end
                end
                SHIFT: begin
                    a_sh <= {a_sh[DATA_WIDTH-2:0], 1'b0};
                    b_sh <= {b_sh[DATA_WIDTH-2:0], 1'b0};
                    cnt  <= cnt - 1'b1;
                    rel  <= rel_next;
                    if (finish) begin
                        done_out    <= 1'b1;
                        a_in_g_b_in <= (rel_next == REL_GT);
                        a_in_e_b_in <= (rel_next == REL_EQ);
                        a_in_l_b_in <= (rel_next == REL_LT);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// tb_serial_comparator: drives directed and random compares, predicting every cycle's outputs
// from a transaction-level model (operand compare plus expected latency in edges).
module tb_serial_comparator;

    localparam int W = 4;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         start_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy_out;
    logic         done_out;
    logic         a_in_g_b_in;
    logic         a_in_e_b_in;
    logic         a_in_l_b_in;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit     m_busy = 1'b0;
    int     m_left = 0;
    int     m_a = 0;
    int     m_b = 0;
    bit     m_done = 1'b0;
    bit [2:0] m_flags = 3'b000;

    serial_comparator #(.DATA_WIDTH(W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (start_in),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy_out    (busy_out),
        .done_out    (done_out),
        .a_in_g_b_in (a_in_g_b_in),
        .a_in_e_b_in (a_in_e_b_in),
        .a_in_l_b_in (a_in_l_b_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %b required %b (busy,done,g,e,l) at %0t",
                     tag, observed[4:0], expected[4:0], $time);
        end
    endtask

    // Edges from capture to done: the index of the first differing bit counted from the MSB when exiting early.
    function automatic int expLatency(input int a, input int b);
`ifdef EARLY_EXIT_EN
        for (int k = 1; k <= W; k++) begin
            if (((a >> (W - k)) & 1) != ((b >> (W - k)) & 1)) return k;
        end
        return W;
`else
        return W;
`endif
    endfunction

    function automatic logic [31:0] modelOutputs();
        return {27'd0, m_busy, m_done, m_flags};
    endfunction

    function automatic logic [31:0] dutOutputs();
        return {27'd0, busy_out, done_out, a_in_g_b_in, a_in_e_b_in, a_in_l_b_in};
    endfunction

    // One cycle: check outputs, drive inputs for the next rising edge, then advance the model across it.
    task automatic applyStimulus(input string tag, input bit start, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk_in);
        checkOutput(tag, dutOutputs(), modelOutputs());
        start_in = start;
        a_in     = a;
        b_in     = b;
        m_done   = 1'b0;
        if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_a    = int'(a);
                m_b    = int'(b);
                m_left = expLatency(m_a, m_b);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_flags = {m_a > m_b, m_a == m_b, m_a < m_b};
            end
        end
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk_in);
        rst_in   = 1'b1;
        start_in = 1'b0;
        #1;
        checkOutput(tag, dutOutputs(), 32'd0);
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_left  = 0;
        m_flags = 3'b000;
        #2;
        rst_in = 1'b0;
    endtask

    task automatic runCompare(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        applyStimulus(tag, 1'b1, a, b);
        repeat (W + 2) applyStimulus(tag, 1'b0, 4'($urandom()), 4'($urandom()));
    endtask

    initial begin
        $display("[TB] serial_comparator bench, DATA_WIDTH=%0d", W);
        #1;
        checkOutput("reset_state", dutOutputs(), 32'd0);
        applyStimulus("reset_hold", 1'b0, 4'h0, 4'h0);
        rst_in = 1'b0;

        runCompare("gt_1010_0110", 4'b1010, 4'b0110);
        runCompare("eq_F_F", 4'hF, 4'hF);
        runCompare("lt_0_1", 4'h0, 4'h1);
        runCompare("gt_8_0", 4'h8, 4'h0);

        // Start while busy must be ignored
        applyStimulus("busy_ignore", 1'b1, 4'h3, 4'h5);
        applyStimulus("busy_ignore", 1'b0, 4'h0, 4'h0);
        applyStimulus("busy_ignore", 1'b1, 4'hF, 4'h0);
        repeat (W + 2) applyStimulus("busy_ignore", 1'b0, 4'hF, 4'h0);

        // Abort mid-compare
        applyStimulus("mid_reset", 1'b1, 4'h9, 4'h9);
        applyStimulus("mid_reset", 1'b0, 4'h0, 4'h0);
        applyStimulus("mid_reset", 1'b0, 4'h0, 4'h0);
        applyReset("mid_reset_async");
        runCompare("after_reset_eq7", 4'h7, 4'h7);

        // Sustained start, fixed then changing operands
        repeat (16) applyStimulus("sustain_fixed", 1'b1, 4'h9, 4'h2);
        repeat (30) applyStimulus("sustain_vary", 1'b1, 4'($urandom()), 4'($urandom()));

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                applyReset("random_reset");
            end else begin
                applyStimulus("random", ($urandom_range(0, 2) != 0), 4'($urandom()), 4'($urandom()));
            end
        end
        repeat (W + 2) applyStimulus("drain", 1'b0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
